// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, function
// codes, FSM states, ALU operations and instruction classes.
package mc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_NOP
    } instr_class_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_cpu_hs_if.sv
// Request/ready memory port shared by the core (master) and the memory (slave).
interface mc_cpu_hs_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port; r0 reads as zero and ignores writes. Contents are not reset.
module mc_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
endmodule

// File: rtl/mc_cpu_hs.sv
// Multicycle MIPS-subset core with a stallable request/ready memory port.
// Define MC_CPU_PERF_EN to build the cycle/instruction performance counters.
module mc_cpu_hs
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_cpu_hs_if.master      mem,
    output logic [31:0]      pc,
    output logic             halt,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    state_t       state;
    logic [31:0]  ir, a_reg, b_reg, alu_out, mdr, wait_cnt;
    logic [31:0]  addr_q, wdata_q;
    logic         we_q;

    logic [5:0]   opcode, funct;
    logic [4:0]   rs, rt, rd, shamt;
    logic [15:0]  imm;
    logic [25:0]  imm26;

    instr_class_t cls;
    alu_op_t      alu_op;
    logic         use_imm;
    logic [31:0]  imm_ext, alu_b, alu_res, mem_off, jump_target;
    logic [4:0]   wb_reg;

    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata, rf_a, rf_b;
    logic         timed_out;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign imm26  = ir[25:0];

    // Request is gated by rst so an in-flight access is abandoned immediately.
    assign mem.mem_req   = (state == FETCH || state == MEM) && !rst;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    always_comb begin
        cls     = CLS_NOP;
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm_ext = sext16(imm);
        wb_reg  = rt;
        case (opcode)
            OP_RTYPE: begin
                wb_reg = rd;
                cls    = CLS_ALU;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_JR:   cls    = CLS_JR;
                    default: cls    = CLS_NOP;
                endcase
            end
            OP_ADDI: begin cls = CLS_ALU; use_imm = 1'b1; alu_op = ALU_ADD; end
            OP_SLTI: begin cls = CLS_ALU; use_imm = 1'b1; alu_op = ALU_SLT; end
            OP_ANDI: begin cls = CLS_ALU; use_imm = 1'b1; alu_op = ALU_AND; imm_ext = {16'd0, imm}; end
            OP_ORI:  begin cls = CLS_ALU; use_imm = 1'b1; alu_op = ALU_OR;  imm_ext = {16'd0, imm}; end
            OP_LUI:  begin cls = CLS_ALU; use_imm = 1'b1; alu_op = ALU_LUI; end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_NOP;
        endcase
    end

    always_comb begin
        alu_b   = use_imm ? imm_ext : b_reg;
        alu_res = a_reg + alu_b;
        case (alu_op)
            ALU_ADD: alu_res = a_reg + alu_b;
            ALU_SUB: alu_res = a_reg - alu_b;
            ALU_AND: alu_res = a_reg & alu_b;
            ALU_OR:  alu_res = a_reg | alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
            ALU_SLL: alu_res = b_reg << shamt;
            ALU_SRL: alu_res = b_reg >> shamt;
            ALU_LUI: alu_res = {imm, 16'd0};
            default: alu_res = a_reg + alu_b;
        endcase
    end

    assign mem_off     = a_reg + sext16(imm);
    assign jump_target = {pc[31:28], imm26, 2'b00};
    assign timed_out   = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

    // jal writes the already-incremented pc into r31 during EXEC.
    assign rf_we    = (state == WB) || (state == EXEC && cls == CLS_JAL);
    assign rf_waddr = (state == EXEC) ? 5'd31 : wb_reg;
    assign rf_wdata = (state == EXEC) ? pc : ((cls == CLS_LW) ? mdr : alu_out);

    mc_regfile u_regfile (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // Main sequencer; mem_addr is always preloaded with the next access address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            wait_cnt <= '0;
            addr_q   <= RESET_PC;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            halt     <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem.mem_ready) begin
                        ir       <= mem.mem_rdata;
                        pc       <= pc + 32'd4;
                        addr_q   <= pc + 32'd4;
                        wait_cnt <= '0;
                        if (mem.mem_rdata == HALT_INSTR) begin
                            state <= HALT;
                            halt  <= 1'b1;
                        end else begin
                            state <= DECODE;
                        end
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        state   <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    a_reg   <= rf_a;
                    b_reg   <= rf_b;
                    alu_out <= pc + (sext16(imm) << 2);
                    state   <= EXEC;
                end
                EXEC: begin
                    case (cls)
                        CLS_ALU: begin
                            alu_out <= alu_res;
                            state   <= WB;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_out <= mem_off;
                            addr_q  <= mem_off;
                            we_q    <= (cls == CLS_SW);
                            wdata_q <= b_reg;
                            state   <= MEM;
                        end
                        CLS_BEQ, CLS_BNE: begin
                            if ((a_reg == b_reg) == (cls == CLS_BEQ)) begin
                                pc     <= alu_out;
                                addr_q <= alu_out;
                            end
                            state <= FETCH;
                        end
                        CLS_J, CLS_JAL: begin
                            pc     <= jump_target;
                            addr_q <= jump_target;
                            state  <= FETCH;
                        end
                        CLS_JR: begin
                            pc     <= a_reg;
                            addr_q <= a_reg;
                            state  <= FETCH;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        we_q     <= 1'b0;
                        addr_q   <= pc;
                        wait_cnt <= '0;
                        if (we_q) begin
                            state <= FETCH;
                        end else begin
                            mdr   <= mem.mem_rdata;
                            state <= WB;
                        end
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        state   <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WB:      state <= FETCH;
                default: state <= state;
            endcase
        end
    end

`ifdef MC_CPU_PERF_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q, instr_q;

    assign retire = (state == WB)
                 || (state == EXEC && cls != CLS_ALU && cls != CLS_LW && cls != CLS_SW)
                 || (state == MEM && mem.mem_ready && we_q);

    // Cycles stop counting once the core parks in HALT or ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state != HALT && state != ERR) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (retire) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_cpu_hs.sv
// Self-checking bench for mc_cpu_hs: directed and random programs run against
// an instruction-level reference model, plus timeout and reset-abort scenarios.
module tb_mc_cpu_hs;

`ifdef MC_CPU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int OP_R = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5;
    localparam int OP_ADDI = 8, OP_SLTI = 10, OP_ANDI = 12, OP_ORI = 13;
    localparam int OP_LUI = 15, OP_LW = 35, OP_SW = 43;
    localparam int FN_SLL = 0, FN_SRL = 2, FN_JR = 8, FN_ADD = 32;
    localparam int FN_SUB = 34, FN_AND = 36, FN_OR = 37, FN_SLT = 42;

    logic clk, rst, rst_to;
    logic [31:0] pc, pc_to;
    logic halt, bus_err, halt_to, bus_err_to;
    logic [31:0] cycle_cnt, instr_cnt, cycle_cnt_to, instr_cnt_to;

    mc_cpu_hs_if mif ();
    mc_cpu_hs_if mif_to ();

    mc_cpu_hs #(.RESET_PC(32'h0), .TIMEOUT(0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem(mif), .pc(pc), .halt(halt), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    mc_cpu_hs #(.RESET_PC(32'h0), .TIMEOUT(8), .CNT_W(32)) dut_to (
        .clk(clk), .rst(rst_to), .mem(mif_to), .pc(pc_to), .halt(halt_to), .bus_err(bus_err_to),
        .cycle_cnt(cycle_cnt_to), .instr_cnt(instr_cnt_to)
    );

    always #5 clk = ~clk;

    // Memory with a fixed number of wait states per access, owned by one process.
    logic [31:0] mem [0:1023];
    logic [31:0] img [0:1023];
    logic        load_now, stall_wr, in_acc;
    int          cur_waits, wcnt, unstable, badlen;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    assign mif.mem_ready = mif.mem_req && (wcnt >= cur_waits) && !(stall_wr && mif.mem_we);
    assign mif.mem_rdata = mem[mif.mem_addr[11:2]];
    assign mif_to.mem_ready = 1'b0;
    assign mif_to.mem_rdata = 32'h0;

    initial begin
        wcnt = 0; unstable = 0; badlen = 0; in_acc = 1'b0;
        h_addr = 0; h_wdata = 0; h_we = 1'b0;
    end

    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img[i];
        end
        if (mif.mem_req) begin
            if (in_acc && (mif.mem_addr != h_addr || mif.mem_we != h_we || mif.mem_wdata != h_wdata))
                unstable <= unstable + 1;
            h_addr  <= mif.mem_addr;
            h_we    <= mif.mem_we;
            h_wdata <= mif.mem_wdata;
            if (mif.mem_ready) begin
                if (mif.mem_we) mem[mif.mem_addr[11:2]] <= mif.mem_wdata;
                if (wcnt != cur_waits) badlen <= badlen + 1;
                wcnt   <= 0;
                in_acc <= 1'b0;
            end else begin
                wcnt   <= wcnt + 1;
                in_acc <= 1'b1;
            end
        end else begin
            wcnt   <= 0;
            in_acc <= 1'b0;
        end
    end

    int compared, mismatched;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {6'(op), 26'(target >> 2)};
    endfunction

    // Instruction-level reference: architectural effect plus cycle cost per class.
    logic [31:0] prog[$];
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_rf [0:31];
    logic [31:0] m_pc;
    int          m_cycles, m_instrs;

    task automatic model_run(input int waits);
        logic [31:0] ins, va, vb, simm, zimm, npc, res, ea;
        int lat, acc;
        bit wr;
        int wreg;
        m_pc = 0; m_cycles = 0; m_instrs = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        for (int step = 0; step < 2000; step++) begin
            ins = m_mem[m_pc[11:2]];
            if (ins == 32'h0) begin
                m_pc = m_pc + 4;
                m_cycles += 1 + waits;
                break;
            end
            va = m_rf[ins[25:21]];
            vb = m_rf[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            zimm = {16'd0, ins[15:0]};
            npc = m_pc + 4;
            lat = 4; acc = 1; wr = 0; wreg = int'(ins[20:16]); res = 0;
            case (int'(ins[31:26]))
                OP_R: begin
                    wr = 1; wreg = int'(ins[15:11]);
                    case (int'(ins[5:0]))
                        FN_ADD: res = va + vb;
                        FN_SUB: res = va - vb;
                        FN_AND: res = va & vb;
                        FN_OR:  res = va | vb;
                        FN_SLT: res = ($signed(va) < $signed(vb)) ? 1 : 0;
                        FN_SLL: res = vb << ins[10:6];
                        FN_SRL: res = vb >> ins[10:6];
                        FN_JR:  begin wr = 0; lat = 3; npc = va; end
                        default: begin wr = 0; lat = 3; end
                    endcase
                end
                OP_ADDI: begin wr = 1; res = va + simm; end
                OP_SLTI: begin wr = 1; res = ($signed(va) < $signed(simm)) ? 1 : 0; end
                OP_ANDI: begin wr = 1; res = va & zimm; end
                OP_ORI:  begin wr = 1; res = va | zimm; end
                OP_LUI:  begin wr = 1; res = zimm << 16; end
                OP_LW:   begin ea = va + simm; wr = 1; res = m_mem[ea[11:2]]; lat = 5; acc = 2; end
                OP_SW:   begin ea = va + simm; m_mem[ea[11:2]] = vb; acc = 2; end
                OP_BEQ:  begin lat = 3; if (va == vb) npc = m_pc + 4 + (simm << 2); end
                OP_BNE:  begin lat = 3; if (va != vb) npc = m_pc + 4 + (simm << 2); end
                OP_J:    begin lat = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
                OP_JAL:  begin lat = 3; wr = 1; wreg = 31; res = m_pc + 4; npc = {npc[31:28], ins[25:0], 2'b00}; end
                default: lat = 3;
            endcase
            if (wr && wreg != 0) m_rf[wreg] = res;
            m_pc = npc;
            m_cycles += lat + waits * acc;
            m_instrs++;
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) img[i] = prog[i];
        img[64] = 32'hDEAD_BEEF;
        for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
    endtask

    task automatic apply_stimulus(input int waits, input string name);
        int ncyc;
        load_image();
        cur_waits = waits;
        stall_wr = 1'b0;
        rst = 1'b1;
        load_now = 1'b1;
        @(posedge clk); #1;
        load_now = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ncyc = 0;
        do begin
            @(posedge clk); #1;
            ncyc++;
        end while (!halt && ncyc < 4000);
        model_run(waits);
        check_output({name, "_halt"}, 32'(halt), 32'd1);
        check_output({name, "_cycles"}, ncyc, m_cycles);
        check_output({name, "_pc"}, pc, m_pc);
        check_output({name, "_bus_err"}, 32'(bus_err), 32'd0);
        check_output({name, "_instr_cnt"}, instr_cnt, PERF ? m_instrs : 0);
        check_output({name, "_cycle_cnt"}, cycle_cnt, PERF ? m_cycles : 0);
        check_output({name, "_addr_stable"}, unstable, 0);
        check_output({name, "_access_len"}, badlen, 0);
        for (int i = 64; i < 72; i++) check_output($sformatf("%s_mem%0d", name, i), mem[i], m_mem[i]);
        for (int i = 128; i < 136; i++) check_output($sformatf("%s_mem%0d", name, i), mem[i], m_mem[i]);
    endtask

    task automatic build_prog1();
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 0, 1, 5));
        prog.push_back(enc_i(OP_ADDI, 0, 2, -3));
        prog.push_back(enc_r(FN_ADD, 1, 2, 3, 0));
        prog.push_back(enc_i(OP_SW, 0, 3, 32'h100));
        prog.push_back(32'h0);
    endtask

    task automatic build_flow_prog();
        prog = {};
        repeat (19) prog.push_back(32'h0);
        prog[0]  = enc_i(OP_ADDI, 0, 5, 7);
        prog[1]  = enc_i(OP_BEQ, 0, 0, 2);
        prog[2]  = enc_i(OP_ADDI, 0, 5, 1);
        prog[3]  = enc_i(OP_ADDI, 0, 5, 2);
        prog[4]  = enc_i(OP_BNE, 5, 5, 5);
        prog[5]  = enc_j(OP_JAL, 32'h40);
        prog[6]  = enc_i(OP_SW, 0, 31, 32'h104);
        prog[7]  = enc_i(OP_SW, 0, 5, 32'h108);
        prog[8]  = enc_i(OP_LW, 0, 6, 32'h100);
        prog[9]  = enc_i(OP_SW, 0, 6, 32'h10C);
        prog[16] = enc_i(OP_ADDI, 0, 7, 32'h55);
        prog[17] = enc_i(OP_SW, 0, 7, 32'h110);
        prog[18] = enc_r(FN_JR, 31, 0, 0, 0);
    endtask

    task automatic build_random_prog();
        int k, d, s, t, imm, sh;
        prog = {};
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_ADDI, 0, r, int'($urandom_range(0, 65535))));
        repeat (12) begin
            k = int'($urandom_range(0, 11));
            d = int'($urandom_range(1, 7));
            s = int'($urandom_range(1, 7));
            t = int'($urandom_range(1, 7));
            imm = int'($urandom_range(0, 65535));
            sh = int'($urandom_range(0, 31));
            case (k)
                0:  prog.push_back(enc_r(FN_ADD, s, t, d, 0));
                1:  prog.push_back(enc_r(FN_SUB, s, t, d, 0));
                2:  prog.push_back(enc_r(FN_AND, s, t, d, 0));
                3:  prog.push_back(enc_r(FN_OR, s, t, d, 0));
                4:  prog.push_back(enc_r(FN_SLT, s, t, d, 0));
                5:  prog.push_back(enc_r(FN_SLL, 0, t, d, sh));
                6:  prog.push_back(enc_r(FN_SRL, 0, t, d, sh));
                7:  prog.push_back(enc_i(OP_ADDI, s, d, imm));
                8:  prog.push_back(enc_i(OP_SLTI, s, d, imm));
                9:  prog.push_back(enc_i(OP_ANDI, s, d, imm));
                10: prog.push_back(enc_i(OP_ORI, s, d, imm));
                default: prog.push_back(enc_i(OP_LUI, 0, d, imm));
            endcase
        end
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_SW, 0, r, 32'h200 + 4 * r));
        prog.push_back(32'h0);
    endtask

    initial begin
        int n;
        logic [31:0] frozen;
        clk = 1'b0; rst = 1'b1; rst_to = 1'b1;
        load_now = 1'b0; stall_wr = 1'b0; cur_waits = 0;
        compared = 0; mismatched = 0;
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;

        // Reset state
        @(posedge clk); #1;
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_req", 32'(mif.mem_req), 32'd0);
        check_output("rst_we", 32'(mif.mem_we), 32'd0);
        check_output("rst_addr", mif.mem_addr, 32'h0);
        check_output("rst_wdata", mif.mem_wdata, 32'h0);
        check_output("rst_halt", 32'(halt), 32'd0);
        check_output("rst_bus_err", 32'(bus_err), 32'd0);
        check_output("rst_cycle_cnt", cycle_cnt, 32'd0);
        check_output("rst_instr_cnt", instr_cnt, 32'd0);

        $display("[TB] program 1, zero wait");
        build_prog1();
        apply_stimulus(0, "p1");
        check_output("p1_result", mem[64], 32'd2);

        $display("[TB] control flow program, zero and three wait states");
        build_flow_prog();
        apply_stimulus(0, "flow_w0");
        check_output("flow_w0_r31", mem[65], 32'h18);
        build_flow_prog();
        apply_stimulus(3, "flow_w3");
        check_output("flow_w3_lw", mem[67], 32'hDEAD_BEEF);

        $display("[TB] random ALU programs");
        for (int it = 0; it < 4; it++) begin
            build_random_prog();
            apply_stimulus(int'($urandom_range(0, 2)), $sformatf("rnd%0d", it));
        end

        $display("[TB] reset during stalled store");
        build_prog1();
        load_image();
        cur_waits = 0;
        stall_wr = 1'b1;
        rst = 1'b1; load_now = 1'b1;
        @(posedge clk); #1;
        load_now = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(mif.mem_req && mif.mem_we) && n < 100);
        check_output("stall_seen", 32'(mif.mem_req && mif.mem_we), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_output("stall_req_held", 32'(mif.mem_req), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_output("rst_req_drop", 32'(mif.mem_req), 32'd0);
        check_output("rst_mid_pc", pc, 32'h0);
        @(negedge clk);
        stall_wr = 1'b0;
        rst = 1'b0;
        #1;
        check_output("restart_req", 32'(mif.mem_req), 32'd1);
        check_output("restart_addr", mif.mem_addr, 32'h0);
        check_output("restart_halt", 32'(halt), 32'd0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!halt && n < 200);
        check_output("restart_done", 32'(halt), 32'd1);
        check_output("restart_result", mem[64], 32'd2);

        $display("[TB] timeout with ready held low");
        @(negedge clk);
        rst_to = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("to_wait%0d_err", k), 32'(bus_err_to), 32'd0);
        end
        @(posedge clk); #1;
        check_output("to_bus_err", 32'(bus_err_to), 32'd1);
        check_output("to_req_drop", 32'(mif_to.mem_req), 32'd0);
        check_output("to_cycle_cnt", cycle_cnt_to, PERF ? 32'd8 : 32'd0);
        frozen = cycle_cnt_to;
        repeat (5) @(posedge clk);
        #1;
        check_output("to_cycle_frozen", cycle_cnt_to, frozen);
        check_output("to_instr_cnt", instr_cnt_to, 32'd0);
        check_output("to_err_sticky", 32'(bus_err_to), 32'd1);
        check_output("to_halt", 32'(halt_to), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
